// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide scheduler beside the EX-stage ALU.
// Runs an iterative shift-add multiply or restoring divide and stalls the pipeline meanwhile.
module muldiv_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]      op_a,
    input  logic [WIDTH-1:0]      op_b,
    output logic [WIDTH-1:0]      result,
    output logic [WIDTH-1:0]      remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic                  stall
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CTRL_WIDTH-1:0] CtrlMul = CTRL_WIDTH'(4'b0101);
    localparam logic [CTRL_WIDTH-1:0] CtrlDiv = CTRL_WIDTH'(4'b0111);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic              op_div_q, op_div_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    // a: multiplicand (shifts left) or dividend/quotient; b: multiplier or divisor;
    // acc: product accumulator or partial remainder.
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;

    logic              is_mul;
    logic              is_div;
    logic              accept;
    logic [WIDTH-1:0]  mul_acc;
    logic [WIDTH:0]    rem_ext;
    logic              rem_ge;
    logic [WIDTH-1:0]  div_rem;
    logic [WIDTH-1:0]  div_quo;

    always_comb begin
        is_mul = (alu_ctrl == CtrlMul);
        is_div = (alu_ctrl == CtrlDiv);
        accept = start && (state_q == StIdle || state_q == StDone) && (is_mul || is_div);
    end

    // One iteration of each algorithm, evaluated every cycle and used only in StRun.
    always_comb begin
        mul_acc = b_q[0] ? (acc_q + a_q) : acc_q;
        rem_ext = {acc_q, a_q[WIDTH-1]};
        rem_ge  = (rem_ext >= {1'b0, b_q});
        // The difference is below the divisor, so the low WIDTH bits are exact.
        div_rem = rem_ge ? (rem_ext[WIDTH-1:0] - b_q) : rem_ext[WIDTH-1:0];
        div_quo = {a_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        op_div_d    = op_div_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    op_div_d = is_div;
                    a_d      = op_a;
                    b_d      = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    if (is_div && op_b == '0) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        result_d    = '1;
                        remainder_d = op_a;
                    end else begin
                        state_d = StRun;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (op_div_q) begin
                    acc_d = div_rem;
                    a_d   = div_quo;
                end else begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end
                if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = op_div_q ? div_quo : mul_acc;
                    remainder_d = op_div_q ? div_rem : '0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            op_div_q    <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            op_div_q    <= op_div_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
        end
    end

    assign result      = result_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign stall       = accept | busy_q;

endmodule
